seq_divider: RTL

//  Multi-cycle unsigned restoring divider for the ALU: one quotient bit per cycle.

---
 rtl/seq_divider_pkg.sv | 25 ++
 rtl/seq_divider_ripple_sub.sv | 26 ++
 rtl/seq_divider.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types for the sequential divider: FSM state encoding and the full-subtractor bit cell.
package seq_divider_pkg;

  localparam int unsigned SEQDIV_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    SEQDIV_IDLE = 2'd0,
    SEQDIV_RUN  = 2'd1,
    SEQDIV_DONE = 2'd2
  } seqdiv_state_e;

  typedef struct packed {
    logic diff;
    logic borrow;
  } sub_bit_t;

  // One-bit full subtractor: a - b - bin
  function automatic sub_bit_t full_sub(input logic a, input logic b, input logic bin);
    sub_bit_t r;
    r.diff   = a ^ b ^ bin;
    r.borrow = (~a & b) | (~(a ^ b) & bin);
    return r;
  endfunction

endpackage

// File: rtl/seq_divider_ripple_sub.sv
// N-bit ripple-borrow subtractor (a - b) built from full_sub cells; borrow-in tied low.
module seq_divider_ripple_sub
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = SEQDIV_DEFAULT_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_out
);

  logic [N:0] borrow_c;

  assign borrow_c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_cell
    sub_bit_t cell_c;
    assign cell_c          = full_sub(a[i], b[i], borrow_c[i]);
    assign diff[i]         = cell_c.diff;
    assign borrow_c[i + 1] = cell_c.borrow;
  end

  assign borrow_out = borrow_c[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle with valid/ready handshake.
// Define SEQ_DIVIDER_DZ_FAST_EN to short-circuit divide-by-zero straight to DONE with a flag.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = SEQDIV_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seqdiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             ready_q, ready_d;
  logic             out_valid_q, out_valid_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   s_c, t_c;
  logic             borrow_c;
  logic             unused_r_msb;

  // Partial remainder shifted left with the next dividend bit brought in
  assign s_c          = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign unused_r_msb = r_q[WIDTH];

  seq_divider_ripple_sub #(
    .N (WIDTH + 1)
  ) u_sub (
    .a          (s_c),
    .b          ({1'b0, d_q}),
    .diff       (t_c),
    .borrow_out (borrow_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEQDIV_IDLE;
      count_q     <= '0;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      dz_q        <= dz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    ready_d     = ready_q;
    out_valid_d = out_valid_q;
    dz_d        = dz_q;

    unique case (state_q)
      SEQDIV_IDLE: begin
        if (start) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          count_d = CNT_W'(WIDTH - 1);
          ready_d = 1'b0;
`ifdef SEQ_DIVIDER_DZ_FAST_EN
          if (divisor == '0) begin
            state_d     = SEQDIV_DONE;
            out_valid_d = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            dz_d        = 1'b1;
          end else begin
            state_d = SEQDIV_RUN;
          end
`else
          state_d = SEQDIV_RUN;
`endif
        end
      end

      SEQDIV_RUN: begin
        // Restore on borrow: keep the shifted remainder and record a zero quotient bit
        r_d = borrow_c ? s_c : t_c;
        q_d = {q_q[WIDTH-2:0], ~borrow_c};
        if (count_q == '0) begin
          state_d     = SEQDIV_DONE;
          out_valid_d = 1'b1;
          quotient_d  = {q_q[WIDTH-2:0], ~borrow_c};
          remainder_d = borrow_c ? s_c[WIDTH-1:0] : t_c[WIDTH-1:0];
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end

      SEQDIV_DONE: begin
        if (out_ready) begin
          state_d     = SEQDIV_IDLE;
          ready_d     = 1'b1;
          out_valid_d = 1'b0;
          dz_d        = 1'b0;
        end
      end

      default: begin
        state_d     = SEQDIV_IDLE;
        ready_d     = 1'b1;
        out_valid_d = 1'b0;
        dz_d        = 1'b0;
      end
    endcase
  end

  assign ready       = ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;

endmodule
